// File: rtl/prog_mem_arbiter.sv
// rtl/prog_mem_arbiter.sv - round-robin arbiter sharing one program-memory read port between fetchers.
// Optional last-fetch bypass register enabled by defining PROG_ARB_BYPASS_EN.
module prog_mem_arbiter #(
    parameter int NUM_CONSUMERS = 4,
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
    output logic                               mem_read_valid,
    output logic [ADDR_BITS-1:0]               mem_read_address,
    input  logic                               mem_read_ready,
    input  logic [DATA_BITS-1:0]               mem_read_data,
    output logic                               busy
);

    localparam int IDX_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        RESPOND  = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [IDX_BITS-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IDX_BITS-1:0]        grant_q, grant_d;
    logic                       mem_valid_q, mem_valid_d;
    logic [ADDR_BITS-1:0]       mem_addr_q, mem_addr_d;
    logic [NUM_CONSUMERS-1:0]   ready_q, ready_d;
    logic                       busy_q, busy_d;
    logic [DATA_BITS-1:0]       data_q [NUM_CONSUMERS];
    logic [DATA_BITS-1:0]       data_d [NUM_CONSUMERS];
    logic [ADDR_BITS-1:0]       req_addr [NUM_CONSUMERS];

    logic                       scan_found;
    logic [IDX_BITS-1:0]        scan_winner;
    logic                       bypass_hit;

`ifdef PROG_ARB_BYPASS_EN
    logic                       last_valid_q, last_valid_d;
    logic [ADDR_BITS-1:0]       last_addr_q, last_addr_d;
    logic [DATA_BITS-1:0]       last_data_q, last_data_d;
`endif

    for (genvar i = 0; i < NUM_CONSUMERS; i++) begin : g_pack
        assign req_addr[i] = consumer_read_address[i*ADDR_BITS +: ADDR_BITS];
        assign consumer_read_data[i*DATA_BITS +: DATA_BITS] = data_q[i];
    end

    assign consumer_read_ready = ready_q;
    assign mem_read_valid      = mem_valid_q;
    assign mem_read_address    = mem_addr_q;
    assign busy                = busy_q;

    // Scan starts at rr_ptr so the consumer served last is checked last.
    always_comb begin
        logic [IDX_BITS-1:0] scan_idx;
        scan_idx    = '0;
        scan_found  = 1'b0;
        scan_winner = '0;
        for (int i = 0; i < NUM_CONSUMERS; i++) begin
            scan_idx = IDX_BITS'((int'(rr_ptr_q) + i) % NUM_CONSUMERS);
            if (!scan_found && consumer_read_valid[scan_idx]) begin
                scan_found  = 1'b1;
                scan_winner = scan_idx;
            end
        end
    end

`ifdef PROG_ARB_BYPASS_EN
    assign bypass_hit = last_valid_q && (req_addr[scan_winner] == last_addr_q);
`else
    assign bypass_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        ready_d     = ready_q;
        data_d      = data_q;
`ifdef PROG_ARB_BYPASS_EN
        last_valid_d = last_valid_q;
        last_addr_d  = last_addr_q;
        last_data_d  = last_data_q;
`endif
        case (state_q)
            IDLE: begin
                if (scan_found) begin
                    grant_d = scan_winner;
`ifdef PROG_ARB_BYPASS_EN
                    if (bypass_hit) begin
                        data_d[scan_winner]  = last_data_q;
                        ready_d[scan_winner] = 1'b1;
                        state_d              = RESPOND;
                    end else begin
                        mem_valid_d = 1'b1;
                        mem_addr_d  = req_addr[scan_winner];
                        state_d     = WAIT_MEM;
                    end
`else
                    mem_valid_d = 1'b1;
                    mem_addr_d  = req_addr[scan_winner];
                    state_d     = WAIT_MEM;
`endif
                end
            end
            WAIT_MEM: begin
                // A consumer dropping valid here is a protocol error; finish anyway.
                if (mem_read_ready) begin
                    mem_valid_d      = 1'b0;
                    data_d[grant_q]  = mem_read_data;
                    ready_d[grant_q] = 1'b1;
                    state_d          = RESPOND;
`ifdef PROG_ARB_BYPASS_EN
                    last_valid_d = 1'b1;
                    last_addr_d  = mem_addr_q;
                    last_data_d  = mem_read_data;
`endif
                end
            end
            RESPOND: begin
                if (!consumer_read_valid[grant_q]) begin
                    ready_d[grant_q] = 1'b0;
                    rr_ptr_d         = IDX_BITS'((int'(grant_q) + 1) % NUM_CONSUMERS);
                    state_d          = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            ready_q     <= '0;
            busy_q      <= 1'b0;
            for (int i = 0; i < NUM_CONSUMERS; i++) begin
                data_q[i] <= '0;
            end
`ifdef PROG_ARB_BYPASS_EN
            last_valid_q <= 1'b0;
            last_addr_q  <= '0;
            last_data_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            data_q      <= data_d;
`ifdef PROG_ARB_BYPASS_EN
            last_valid_q <= last_valid_d;
            last_addr_q  <= last_addr_d;
            last_data_q  <= last_data_d;
`endif
        end
    end

endmodule

// File: tb/tb_prog_mem_arbiter.sv
// tb/tb_prog_mem_arbiter.sv - scoreboard bench for prog_mem_arbiter.
module tb_prog_mem_arbiter;

    localparam int NC = 4;
    localparam int AB = 8;
    localparam int DB = 16;

    typedef struct {
        int          idx;
        logic [15:0] data;
    } exp_t;

    logic               clk;
    logic               reset;
    logic [NC-1:0]      consumer_read_valid;
    logic [NC*AB-1:0]   consumer_read_address;
    logic [NC-1:0]      consumer_read_ready;
    logic [NC*DB-1:0]   consumer_read_data;
    logic               mem_read_valid;
    logic [AB-1:0]      mem_read_address;
    logic               mem_read_ready;
    logic [DB-1:0]      mem_read_data;
    logic               busy;

    int          n_vec = 0;
    int          n_fail = 0;
    int          mem_wait = 0;
    logic        mem_force = 1'b0;
    int          mcnt = 0;
    int          hold [NC];
    int          hcnt [NC];
    int          req_cnt [NC];
    int          issued [NC];
    logic [7:0]  req_addr [NC];
    exp_t        exp_q [$];
    int          pulse_w [$];
    int          rise_cyc [$];
    logic [7:0]  rise_addr [$];
    int          cyc = 0;

    prog_mem_arbiter #(
        .NUM_CONSUMERS(NC),
        .ADDR_BITS    (AB),
        .DATA_BITS    (DB)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .consumer_read_valid  (consumer_read_valid),
        .consumer_read_address(consumer_read_address),
        .consumer_read_ready  (consumer_read_ready),
        .consumer_read_data   (consumer_read_data),
        .mem_read_valid       (mem_read_valid),
        .mem_read_address     (mem_read_address),
        .mem_read_ready       (mem_read_ready),
        .mem_read_data        (mem_read_data),
        .busy                 (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] mem_fn(input logic [7:0] a);
        return (a == 8'h05) ? 16'hA1B2 : {~a, a};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Fetcher agents and program-memory model, both acting on the falling edge.
    initial begin
        consumer_read_valid   = '0;
        consumer_read_address = '0;
        mem_read_ready        = 1'b0;
        mem_read_data         = '0;
        for (int i = 0; i < NC; i++) begin
            hold[i] = 0; hcnt[i] = 0; req_cnt[i] = 0; issued[i] = 0; req_addr[i] = '0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < NC; i++) begin
                if (reset) begin
                    consumer_read_valid[i] = 1'b0;
                    issued[i] = req_cnt[i];
                    hcnt[i] = 0;
                end else if (consumer_read_valid[i] && consumer_read_ready[i]) begin
                    if (hcnt[i] >= hold[i]) begin
                        consumer_read_valid[i] = 1'b0;
                        hcnt[i] = 0;
                    end else begin
                        hcnt[i]++;
                    end
                end else if (!consumer_read_valid[i] && issued[i] != req_cnt[i]) begin
                    consumer_read_valid[i] = 1'b1;
                    consumer_read_address[i*AB +: AB] = req_addr[i];
                    issued[i]++;
                end
            end
            if (mem_force) begin
                mem_read_ready = 1'b1;
                mem_read_data  = 16'h5A5A;
            end else if (mem_read_valid) begin
                mem_read_ready = (mcnt == mem_wait);
                mem_read_data  = mem_read_ready ? mem_fn(mem_read_address) : 16'h0000;
                mcnt++;
            end else begin
                mem_read_ready = 1'b0;
                mem_read_data  = 16'h0000;
                mcnt = 0;
            end
        end
    end

    // Monitor: pops the scoreboard on each response and checks protocol invariants.
    initial begin
        logic [NC-1:0] prev_ready;
        logic          prev_mem_v;
        logic [7:0]    prev_addr;
        logic          prev_rst;
        int            cur_w;
        exp_t          e;
        prev_ready = '0; prev_mem_v = 1'b0; prev_addr = '0; prev_rst = 1'b1; cur_w = 0;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            if (!prev_rst) begin
                for (int i = 0; i < NC; i++) begin
                    if (!prev_ready[i] && consumer_read_ready[i]) begin
                        if (exp_q.size() == 0) begin
                            n_vec++; n_fail++;
                            $display("FAIL unexpected_resp: consumer %0d data %0h", i, consumer_read_data[i*DB +: DB]);
                        end else begin
                            e = exp_q.pop_front();
                            check("resp_consumer", i, e.idx);
                            check("resp_data", consumer_read_data[i*DB +: DB], e.data);
                        end
                    end
                    if (prev_ready[i]) check("ready_follows_valid", consumer_read_ready[i], consumer_read_valid[i]);
                end
                check("busy", busy, mem_read_valid | (|consumer_read_ready));
                check("one_in_flight", mem_read_valid & (|consumer_read_ready), 1'b0);
                if (prev_mem_v && mem_read_valid) check("mem_addr_stable", mem_read_address, prev_addr);
            end
            if (mem_read_valid && !prev_mem_v) begin
                rise_cyc.push_back(cyc);
                rise_addr.push_back(mem_read_address);
                cur_w = 1;
            end else if (mem_read_valid) begin
                cur_w++;
            end
            if (!mem_read_valid && prev_mem_v) pulse_w.push_back(cur_w);
            prev_ready = consumer_read_ready;
            prev_mem_v = mem_read_valid;
            prev_addr  = mem_read_address;
            prev_rst   = reset;
        end
    end

    task automatic push(input int idx, input logic [15:0] d);
        exp_t e;
        e.idx = idx; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic req(input int idx, input logic [7:0] a);
        req_addr[idx] = a;
        req_cnt[idx]++;
    endtask

    function automatic logic quiet();
        logic q;
        q = (exp_q.size() == 0) && !busy && (consumer_read_valid == '0);
        for (int i = 0; i < NC; i++) if (issued[i] != req_cnt[i]) q = 1'b0;
        return q;
    endfunction

    task automatic wait_done(input int max);
        int k;
        k = 0;
        while (k < max && !quiet()) begin
            @(posedge clk); #2;
            k++;
        end
        if (!quiet()) begin
            n_vec++; n_fail++;
            $display("FAIL wait_done: not quiet after %0d cycles", max);
        end
    endtask

    initial begin
        int n0;
        int k;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("rst_ready", consumer_read_ready, 0);
        check("rst_data", consumer_read_data, 0);
        check("rst_mem_valid", mem_read_valid, 0);
        check("rst_mem_addr", mem_read_address, 0);
        check("rst_busy", busy, 0);
        @(posedge clk); #1 reset = 1'b0;

        // Single fetch, memory waits 2 cycles, consumer holds valid 2 extra cycles.
        mem_wait = 2; hold[0] = 2;
        n0 = pulse_w.size();
        push(0, 16'hA1B2);
        req(0, 8'h05);
        wait_done(60);
        check("single_pulses", pulse_w.size() - n0, 1);
        if (pulse_w.size() > n0) check("single_valid_width", pulse_w[n0], 3);
        if (rise_addr.size() > n0) check("single_addr", rise_addr[n0], 8'h05);
        check("single_ready_low", consumer_read_ready, 0);
        check("single_busy_low", busy, 0);
        check("single_data_kept", consumer_read_data[0 +: DB], 16'hA1B2);
        hold[0] = 0;

        // Reset while waiting for memory, then a stray memory response.
        mem_wait = 5;
        req(2, 8'h33);
        k = 0;
        while (k < 20 && !mem_read_valid) begin @(posedge clk); #2; k++; end
        check("rstmid_reached_wait", mem_read_valid, 1);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #2;
        check("rstmid_ready", consumer_read_ready, 0);
        check("rstmid_data", consumer_read_data, 0);
        check("rstmid_mem_valid", mem_read_valid, 0);
        check("rstmid_mem_addr", mem_read_address, 0);
        check("rstmid_busy", busy, 0);
        mem_force = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        repeat (2) begin
            @(posedge clk); #2;
            check("late_ready_mem_valid", mem_read_valid, 0);
            check("late_ready_ready", consumer_read_ready, 0);
            check("late_ready_busy", busy, 0);
        end
        mem_force = 1'b0;
        wait_done(20);

        // All four at once after reset: served 0,1,2,3.
        mem_wait = 1;
        n0 = pulse_w.size();
        push(0, 16'hEF10); push(1, 16'hEE11); push(2, 16'hED12); push(3, 16'hEC13);
        req(0, 8'h10); req(1, 8'h11); req(2, 8'h12); req(3, 8'h13);
        wait_done(100);
        check("all4_pulses", pulse_w.size() - n0, 4);
        check("all4_data0", consumer_read_data[0*DB +: DB], 16'hEF10);
        check("all4_data1", consumer_read_data[1*DB +: DB], 16'hEE11);
        check("all4_data2", consumer_read_data[2*DB +: DB], 16'hED12);
        check("all4_data3", consumer_read_data[3*DB +: DB], 16'hEC13);

        // Fairness: consumer 1 just served loses to consumer 2.
        push(1, 16'hBF40);
        req(1, 8'h40);
        wait_done(40);
        push(2, 16'hBD42); push(1, 16'hBE41);
        req(1, 8'h41); req(2, 8'h42);
        wait_done(60);
        check("fair_data0_untouched", consumer_read_data[0*DB +: DB], 16'hEF10);

        // Zero-wait memory, back-to-back fetches from consumer 0.
        mem_wait = 0;
        n0 = pulse_w.size();
        push(0, 16'hAF50); push(0, 16'hAF50); push(0, 16'hAF50);
        req(0, 8'h50); req(0, 8'h50); req(0, 8'h50);
        wait_done(60);
        check("zw_pulses", pulse_w.size() - n0, 3);
        for (int j = n0; j < pulse_w.size(); j++) check("zw_width", pulse_w[j], 1);
        for (int j = n0 + 1; j < rise_cyc.size(); j++) check("zw_gap_le4", (rise_cyc[j] - rise_cyc[j-1]) <= 4, 1);

        // Repeat address from a different consumer; bypass skips memory when built in.
        mem_wait = 1;
        n0 = pulse_w.size();
        push(0, 16'hDF20);
        req(0, 8'h20);
        wait_done(40);
        push(3, 16'hDF20);
        req(3, 8'h20);
        wait_done(40);
`ifdef PROG_ARB_BYPASS_EN
        check("bypass_no_mem", pulse_w.size() - n0, 1);
`else
        check("nobypass_mem", pulse_w.size() - n0, 2);
`endif
        push(0, 16'hDE21);
        req(0, 8'h21);
        wait_done(40);
`ifdef PROG_ARB_BYPASS_EN
        check("bypass_miss_mem", pulse_w.size() - n0, 2);
`else
        check("nobypass_miss_mem", pulse_w.size() - n0, 3);
`endif
        if (rise_addr.size() > 0) check("miss_addr", rise_addr[rise_addr.size()-1], 8'h21);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
